// File: rtl/multicycle_control_unit.sv
// Multicycle datapath controller: Moore FSM that drives every datapath enable/select; MCU_MUL_EN enables mul.
// Latency: 3..5 cycles per instruction, mul 3+MUL_LATENCY; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold with stable outputs until mem_ready.
module multicycle_control_unit #(
    parameter int INST_WIDTH  = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INST_WIDTH-1:0] Instruction,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  IorD,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  Branch,
    output logic                  PCEn,
    output logic [1:0]            PCSrc,
    output logic                  RegDst,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ALUControl,
    output logic                  mul_busy,
    output logic                  instr_done,
    output logic                  illegal_op,
    output logic [3:0]            state
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
        S_MEMREAD = 4'd4, S_MEMWB = 4'd5, S_MEMWRITE = 4'd6, S_EXECUTE = 4'd7,
        S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEXEC = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP = 4'd12, S_MULWAIT = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_MUL = 6'b011100;
`ifdef MCU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t     st;
    logic [5:0] op_q, fn_q, op_in, fn_in;
    logic [3:0] cnt;
    logic       is_mul_q;
    logic       unused_inst_bits;

    assign op_in            = Instruction[INST_WIDTH-1 -: 6];
    assign fn_in            = Instruction[5:0];
    assign unused_inst_bits = ^Instruction[INST_WIDTH-7:6];
    assign is_mul_q         = MUL_EN && (fn_q == FN_MUL);
    assign state            = st;

    function automatic logic funct_legal(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            FN_MUL:                                return MUL_EN;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: return 1'b1;
            OP_RTYPE:                            return funct_legal(fn);
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
        case (fn)
            FN_AND:  return 3'b000;
            FN_OR:   return 3'b001;
            FN_SUB:  return 3'b100;
            FN_SLT:  return 3'b110;
            FN_MUL:  return 3'b101;
            default: return 3'b010;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st   <= S_IDLE;
            cnt  <= '0;
            op_q <= '0;
            fn_q <= '0;
        end else begin
            case (st)
                S_IDLE:     st <= S_FETCH;
                S_FETCH:    if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    op_q <= op_in;
                    fn_q <= fn_in;
                    if (!instr_legal(op_in, fn_in)) st <= S_FETCH;
                    else begin
                        case (op_in)
                            OP_LW, OP_SW: st <= S_MEMADR;
                            OP_ADDI:      st <= S_ADDIEXEC;
                            OP_BEQ:       st <= S_BRANCH;
                            OP_J:         st <= S_JUMP;
                            default:      st <= S_EXECUTE;
                        endcase
                    end
                end
                S_MEMADR:   st <= (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) st <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) st <= S_FETCH;
                // Counter starts at LAT-2 so EXECUTE plus the MULWAIT cycles total LAT.
                S_EXECUTE: begin
                    if (is_mul_q && MUL_LATENCY > 1) begin
                        cnt <= 4'(MUL_LATENCY - 2);
                        st  <= S_MULWAIT;
                    end else begin
                        st <= S_ALUWB;
                    end
                end
                S_MULWAIT: begin
                    if (cnt == 4'd0) st <= S_ALUWB;
                    else             cnt <= cnt - 4'd1;
                end
                S_ADDIEXEC: st <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: st <= S_FETCH;
                default:    st <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        mul_busy   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                illegal_op = !instr_legal(op_in, fn_in);
                instr_done = !instr_legal(op_in, fn_in);
            end
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE, S_MULWAIT: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_for_funct(fn_q);
                mul_busy   = is_mul_q;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b100;
                Branch     = 1'b1;
                PCSrc      = 2'b01;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        PCEn = PCWrite | (Branch & Zero);
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-instruction expected signatures, checked on instr_done.
module tb_multicycle_control_unit;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Instruction = '0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn;
    logic [1:0]  PCSrc, ALUSrcB;
    logic        RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [2:0]  ALUControl;
    logic        mul_busy, instr_done, illegal_op;
    logic [3:0]  state;
    logic [20:0] outs;

    multicycle_control_unit #(.INST_WIDTH(32), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCEn(PCEn), .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .mul_busy(mul_busy), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    assign outs = {mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, PCSrc, RegDst,
                   MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, mul_busy, instr_done, illegal_op};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  cyc;
        logic [63:0] seq;
        logic [7:0]  rw, m2r, rdst, mw, memreq, iord, irw, pcen, pcsrc, srca, srcb, alu, mb, ill;
    } rec_t;

    rec_t       exp_q[$];
    string      tag_q[$];
    rec_t       acc, e;
    string      tag;
    int         checks = 0, errors = 0, done_cnt = 0;
    logic [3:0] prev_st = 4'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic rec_t mk(input int cyc, input logic [63:0] seq, input int rw, input int m2r,
                                input int rdst, input int mw, input int memreq, input int iord,
                                input int irw, input int pcen, input int pcsrc, input int srca,
                                input int srcb, input int alu, input int mb, input int ill);
        rec_t r;
        r.cyc = 8'(cyc);  r.seq = seq;        r.rw = 8'(rw);       r.m2r = 8'(m2r);
        r.rdst = 8'(rdst); r.mw = 8'(mw);     r.memreq = 8'(memreq); r.iord = 8'(iord);
        r.irw = 8'(irw);  r.pcen = 8'(pcen);  r.pcsrc = 8'(pcsrc);  r.srca = 8'(srca);
        r.srcb = 8'(srcb); r.alu = 8'(alu);   r.mb = 8'(mb);        r.ill = 8'(ill);
        return r;
    endfunction

    // Monitor: accumulate a signature from FETCH entry, compare when instr_done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (state == 4'd1 && prev_st != 4'd1) acc = '0;
            acc.cyc    += 8'd1;
            acc.seq    = {acc.seq[59:0], state};
            acc.rw     += 8'(RegWrite);
            acc.m2r    += 8'(MemtoReg);
            acc.rdst   += 8'(RegDst);
            acc.mw     += 8'(MemWrite);
            acc.memreq += 8'(mem_req);
            acc.iord   += 8'(IorD);
            acc.irw    += 8'(IRWrite);
            acc.pcen   += 8'(PCEn);
            acc.pcsrc  += 8'(PCSrc);
            acc.srca   += 8'(ALUSrcA);
            acc.srcb   += 8'(ALUSrcB);
            acc.alu    += 8'(ALUControl);
            acc.mb     += 8'(mul_busy);
            acc.ill    += 8'(illegal_op);
            if (instr_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got instr_done in state %0d required none", state);
                end else begin
                    e   = exp_q.pop_front();
                    tag = tag_q.pop_front();
                    chk({tag, ".cycles"},   64'(acc.cyc),    64'(e.cyc));
                    chk({tag, ".states"},   acc.seq,         e.seq);
                    chk({tag, ".RegWrite"}, 64'(acc.rw),     64'(e.rw));
                    chk({tag, ".MemtoReg"}, 64'(acc.m2r),    64'(e.m2r));
                    chk({tag, ".RegDst"},   64'(acc.rdst),   64'(e.rdst));
                    chk({tag, ".MemWrite"}, 64'(acc.mw),     64'(e.mw));
                    chk({tag, ".mem_req"},  64'(acc.memreq), 64'(e.memreq));
                    chk({tag, ".IorD"},     64'(acc.iord),   64'(e.iord));
                    chk({tag, ".IRWrite"},  64'(acc.irw),    64'(e.irw));
                    chk({tag, ".PCEn"},     64'(acc.pcen),   64'(e.pcen));
                    chk({tag, ".PCSrc"},    64'(acc.pcsrc),  64'(e.pcsrc));
                    chk({tag, ".ALUSrcA"},  64'(acc.srca),   64'(e.srca));
                    chk({tag, ".ALUSrcB"},  64'(acc.srcb),   64'(e.srcb));
                    chk({tag, ".ALUCtl"},   64'(acc.alu),    64'(e.alu));
                    chk({tag, ".mul_busy"}, 64'(acc.mb),     64'(e.mb));
                    chk({tag, ".illegal"},  64'(acc.ill),    64'(e.ill));
                end
                done_cnt++;
            end
        end
        prev_st = state;
    end

    // Entered in a FETCH cycle at posedge+1; returns in the next FETCH cycle at posedge+1.
    task automatic run(input string nm, input logic [31:0] ins, input logic z,
                       input int fst, input int mst, input rec_t r);
        int start, f, m;
        bit seen;
        Instruction = ins;
        Zero        = z;
        exp_q.push_back(r);
        tag_q.push_back(nm);
        start = done_cnt;
        f = fst;
        m = mst;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            mem_ready = 1'b1;
            if (state == 4'd1 && f > 0) begin
                mem_ready = 1'b0;
                f--;
            end
            if ((state == 4'd4 || state == 4'd6) && m > 0) begin
                mem_ready = 1'b0;
                m--;
            end
            @(posedge clk);
            #1;
            if (done_cnt != start) begin
                seen = 1'b1;
                break;
            end
        end
        mem_ready = 1'b1;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got no instr_done in 60 cycles required one", nm);
        end
    endtask

    localparam logic [31:0] I_LW   = {6'b100011, 5'd1, 5'd2, 16'h0010};
    localparam logic [31:0] I_SW   = {6'b101011, 5'd1, 5'd3, 16'h0020};
    localparam logic [31:0] I_BEQ  = {6'b000100, 5'd4, 5'd5, 16'hfffe};
    localparam logic [31:0] I_ADD  = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
    localparam logic [31:0] I_SUB  = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100010};
    localparam logic [31:0] I_OR   = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100101};
    localparam logic [31:0] I_SLT  = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101010};
    localparam logic [31:0] I_MUL  = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b011100};
    localparam logic [31:0] I_BADF = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000001};
    localparam logic [31:0] I_ADDI = {6'b001000, 5'd1, 5'd2, 16'h0007};
    localparam logic [31:0] I_J    = {6'b000010, 26'h0000100};
    localparam logic [31:0] I_BADO = {6'b111111, 26'h0000033};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset.state", 64'(state), 64'd0);
        chk("reset.outs", 64'(outs), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release.state", 64'(state), 64'd1);

        run("lw",       I_LW,   1'b0, 0, 0, mk(5, 64'h12345,    1, 1, 0, 0, 2, 1, 1, 1, 0, 1, 5, 6,  0, 0));
        run("sw_stall", I_SW,   1'b0, 0, 3, mk(7, 64'h1236666,  0, 0, 0, 4, 5, 4, 1, 1, 0, 1, 5, 6,  0, 0));
        run("beq_z1",   I_BEQ,  1'b1, 0, 0, mk(3, 64'h129,      0, 0, 0, 0, 1, 0, 1, 2, 1, 1, 3, 8,  0, 0));
        run("beq_z0",   I_BEQ,  1'b0, 0, 0, mk(3, 64'h129,      0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 3, 8,  0, 0));
        run("add",      I_ADD,  1'b1, 0, 0, mk(4, 64'h1278,     1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 3, 6,  0, 0));
        run("sub",      I_SUB,  1'b0, 0, 0, mk(4, 64'h1278,     1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 3, 8,  0, 0));
        run("or",       I_OR,   1'b0, 0, 0, mk(4, 64'h1278,     1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 3, 5,  0, 0));
        run("slt",      I_SLT,  1'b0, 0, 0, mk(4, 64'h1278,     1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 3, 10, 0, 0));
        run("addi",     I_ADDI, 1'b0, 0, 0, mk(4, 64'h12AB,     1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 5, 6,  0, 0));
        run("j",        I_J,    1'b0, 0, 0, mk(3, 64'h12C,      0, 0, 0, 0, 1, 0, 1, 2, 2, 0, 3, 4,  0, 0));
        run("bad_op",   I_BADO, 1'b0, 0, 0, mk(2, 64'h12,       0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 3, 4,  0, 1));
        run("bad_fn",   I_BADF, 1'b0, 0, 0, mk(2, 64'h12,       0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 3, 4,  0, 1));
        run("lw_stall", I_LW,   1'b0, 2, 1, mk(8, 64'h11123445, 1, 1, 0, 0, 5, 2, 1, 1, 0, 1, 7, 10, 0, 0));
`ifdef MCU_MUL_EN
        run("mul",      I_MUL,  1'b0, 0, 0, mk(7, 64'h127DDD8,  1, 0, 1, 0, 1, 0, 1, 1, 0, 4, 3, 24, 4, 0));
        // Interrupt the next mul on its first MULWAIT cycle (counter at LAT-2 = 2).
        Instruction = I_MUL;
        for (int i = 0; i < 10; i++) begin
            if (state == 4'd13) break;
            @(posedge clk);
            #1;
        end
        chk("mulrst.reach", 64'(state), 64'd13);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mulrst.state", 64'(state), 64'd0);
        chk("mulrst.outs", 64'(outs), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mulrst.release", 64'(state), 64'd1);
`else
        run("mul_off",  I_MUL,  1'b0, 0, 0, mk(2, 64'h12,       0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 3, 4,  0, 1));
`endif
        run("j_after",  I_J,    1'b0, 0, 0, mk(3, 64'h12C,      0, 0, 0, 0, 1, 0, 1, 2, 2, 0, 3, 4,  0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no completion required finish within 100000");
        $fatal(1);
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised controller for the multicycle datapath. It replaces single-cycle decoding with a registered state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It stalls on a memory ready handshake and supports a multiply with configurable latency. It sits beside the shared ALU, instruction register and unified memory port, and drives every datapath enable and mux select.

## Interface
- `INST_WIDTH`, 32: instruction width; opcode is `[INST_WIDTH-1 -: 6]`, funct is `[5:0]`.
- `MUL_LATENCY`, 3: ALU cycles a `mul` occupies. Legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `Instruction` in INST_WIDTH: instruction register contents.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `IorD` out 1: address source; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: store strobe.
- `IRWrite` out 1: instruction register load.
- `PCWrite` out 1: unconditional PC write.
- `Branch` out 1: conditional PC write.
- `PCEn` out 1: `PCWrite | (Branch & Zero)`.
- `PCSrc` out 2: next PC select; 00 = ALU, 01 = ALUOut, 10 = jump target.
- `RegDst` out 1: destination register select; 1 = rd, 0 = rt.
- `MemtoReg` out 1: write-back source; 1 = memory data.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A input; 0 = PC, 1 = rs.
- `ALUSrcB` out 2: ALU B input; 00 = rt, 01 = constant 4, 10 = sign-extended immediate.
- `ALUControl` out 3: ALU operation; and 000, or 001, add 010, sub 100, slt 110, mul 101.
- `mul_busy` out 1: a multiply is in progress.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse on an unsupported instruction.
- `state` out 4: current state, for debug.

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEXEC 10, ADDIWB 11, JUMP 12, MULWAIT 13.
- Outputs are decoded from `state` (Moore). Any output not listed for a state is 0.
- IDLE: all outputs 0. Always goes to FETCH on the next cycle.
- FETCH: `mem_req`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUControl`=010, `PCSrc`=00.
  - `IRWrite` and `PCWrite` are asserted only while `mem_ready`=1.
  - Goes to DECODE when `mem_ready`=1; otherwise stays in FETCH.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=10, `ALUControl`=010 (branch target computed into ALUOut).
  - Opcode and funct are latched into internal registers here.
  - Next state by opcode: lw/sw (100011/101011) → MEMADR; R-type (000000) with a legal funct → EXECUTE; addi (001000) → ADDIEXEC; beq (000100) → BRANCH; j (000010) → JUMP.
  - Any other opcode, or an R-type with an unknown funct: `illegal_op`=1 and `instr_done`=1, then → FETCH. No register or memory side effect.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUControl`=010. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `mem_req`=1, `IorD`=1. Waits for `mem_ready`, then → MEMWB.
- MEMWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=1, `instr_done`=1. Then → FETCH.
- MEMWRITE: `mem_req`=1, `IorD`=1, `MemWrite`=1 held until `mem_ready`. On the `mem_ready` cycle `instr_done`=1, then → FETCH.
- EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUControl` from the latched funct.
  - Non-mul, or `MUL_LATENCY`=1: → ALUWB.
  - mul with `MUL_LATENCY`>1: load the wait counter with `MUL_LATENCY`-2, then → MULWAIT.
- MULWAIT: EXECUTE outputs held, `mul_busy`=1. Counter decrements each cycle; at 0 → ALUWB. `mul_busy` is also 1 in EXECUTE for a mul.
- ALUWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0, `instr_done`=1. Then → FETCH.
- ADDIEXEC: `ALUSrcA`=1, `ALUSrcB`=10, `ALUControl`=010. Then → ADDIWB.
- ADDIWB: `RegWrite`=1, `RegDst`=0, `instr_done`=1. Then → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUControl`=100, `Branch`=1, `PCSrc`=01, `instr_done`=1. Then → FETCH.
- JUMP: `PCWrite`=1, `PCSrc`=10, `instr_done`=1. Then → FETCH.

## Timing
- `rst_n` sampled low in any state, including mid-stall or mid-multiply: the next state is IDLE and the counter and latched opcode/funct clear. All outputs are 0 in IDLE.
- Fetch occurs on the cycle after reset is released.
- Cycles per instruction with `mem_ready` tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, mul 3+`MUL_LATENCY`.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable while stalled.
- `mem_ready` asserted outside those three states is ignored.

## Configuration
- `MCU_MUL_EN` defined: funct 011100 is legal, executes with `ALUControl`=101 and takes the MULWAIT path.
- Not defined: funct 011100 is an unknown funct, so `illegal_op` pulses in DECODE. MULWAIT is unreachable and `mul_busy` is tied to 0. `MUL_LATENCY` is ignored.

## Test plan
- Reset hold, release, lw with `mem_ready`=1 → `state` sequence 0,1,2,3,4,5,1; `RegWrite`=`MemtoReg`=1 in state 5 only; `instr_done` pulses once.
- sw with `mem_ready` low 3 cycles in MEMWRITE → `MemWrite`=1 for 4 cycles; `instr_done` on the 4th; next state 1.
- beq with `Zero`=1, then with `Zero`=0 → `PCEn`=1 for the BRANCH cycle in the first case and 0 in the second; both 3 cycles.
- `MCU_MUL_EN`, `MUL_LATENCY`=4, funct 011100 → `ALUControl`=101 and `mul_busy`=1 for 4 cycles; instruction takes 7 cycles. Repeat without the macro → `illegal_op` pulse in DECODE, no `RegWrite`.
- Opcode 111111 → `illegal_op`=1 and `instr_done`=1 in DECODE; back to FETCH; no writes.
- `rst_n` low during MULWAIT with counter at 2 → next `state` 0; all outputs 0; FETCH resumes one cycle after release.
